// File: rtl/subtree_rr_scheduler.sv
// subtree_rr_scheduler: round-robin burst arbiter muxing NUM_REQ children onto one valid/ready port
module subtree_rr_scheduler #(
  parameter int NUM_REQ   = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 8,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          out_src,
  output logic                      busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               grant, accept, release_now;
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int j;
      j = int'(ptr_q) + i;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      if (req_valid[j]) pick = SRC_W'(j);
    end
  end
  assign grant       = (state_q == GRANT);
  assign out_valid   = grant & req_valid[gnt_q];
  assign out_last    = out_valid & req_last[gnt_q];
  assign out_data    = out_valid ? req_data[gnt_q*DATA_W +: DATA_W] : '0;
  assign req_ready   = grant ? (NUM_REQ'(out_ready) << gnt_q) : '0;
  assign out_src     = grant ? gnt_q : '0;
  assign busy        = grant;
  assign accept      = out_valid & out_ready;
  // forced release on the MAX_BEATS-th accepted beat keeps long bursts from starving siblings
  assign release_now = accept & (req_last[gnt_q] | (beat_cnt_q == CNT_W'(MAX_BEATS - 1)));
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = (accept && beat_cnt_q != CNT_W'(MAX_BEATS)) ? beat_cnt_q + 1'b1 : beat_cnt_q;
    if (!grant && |req_valid) begin
      state_d    = GRANT;
      gnt_d      = pick;
      beat_cnt_d = '0;
    end
    if (release_now) begin
      state_d = IDLE;
      ptr_d   = gnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= SRC_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule
